// File: rtl/switch_pkg.sv
// Shared definitions for the switch ingress path: register map, status bit
// positions and default widths.
package switch_pkg;

  // Default configuration
  localparam int MAX_PORTS      = 12;
  localparam int DEF_NUM_PORTS  = 3;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DROP_CNT_W = 16;

  // Register map (4-bit word index)
  localparam logic [3:0] REG_STATUS    = 4'd0;
  localparam logic [3:0] REG_PORT_BASE = 4'd1;
  localparam logic [3:0] REG_CLEAR     = 4'd13;
  localparam logic [3:0] REG_RDEN      = 4'd14;
  localparam logic [3:0] REG_WREN      = 4'd15;

  // Status word layout; port_full overlays the low bits
  localparam int STATUS_WREN_BIT = 8;
  localparam int STATUS_RDEN_BIT = 9;

  // Register index of ingress port p
  function automatic logic [3:0] port_reg_addr(input int p);
    return REG_PORT_BASE + 4'(p);
  endfunction

endpackage

// File: rtl/ingress_port_ctrl.sv
// One ingress port: circular write pointer, occupancy/full against the
// scheduler read pointer, overflow drop counter and registered RAM write port.
// Optional macro INGRESS_DROP_CNT_EN enables the drop counter register.
module ingress_port_ctrl
  import switch_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DROP_CNT_W = DEF_DROP_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  clear,
  input  logic [ADDR_W-1:0]     cons_rd_ptr,
  output logic                  wren,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  output logic [ADDR_W-1:0]     used,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic              wren_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  // One slot stays empty so that full and empty are distinguishable
  assign used = wr_ptr_reg - cons_rd_ptr;
  assign full = (used == '1);

  // Accept a push when space remains; a clear empties the port and kills
  // any write strobe that would otherwise follow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      wren_reg    <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wren_reg <= 1'b0;
      if (clear) begin
        wr_ptr_reg <= cons_rd_ptr;
      end else if (push && !full) begin
        wren_reg    <= 1'b1;
        wr_addr_reg <= wr_ptr_reg;
        wr_data_reg <= push_data;
        wr_ptr_reg  <= wr_ptr_reg + ADDR_W'(1);
      end
    end
  end

`ifdef INGRESS_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  // Count pushes rejected while full, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (clear) begin
      drop_cnt_reg <= '0;
    end else if (push && full && (drop_cnt_reg != '1)) begin
      drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = '0;
`endif

  assign wren    = wren_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: rtl/switch_ingress_writer.sv
// Avalon-MM slave front end: decodes host writes into per-port pushes into
// circular input RAMs, port clears and scheduler control bits, and returns
// status / occupancy words on reads.
// Optional macro INGRESS_DROP_CNT_EN enables per-port drop counters.
module switch_ingress_writer
  import switch_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DROP_CNT_W = DEF_DROP_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          chipselect,
  input  logic                          write,
  input  logic                          read,
  input  logic [3:0]                    address,
  input  logic [31:0]                   writedata,
  output logic [31:0]                   readdata,
  output logic [NUM_PORTS-1:0]          ram_wren,
  output logic [NUM_PORTS*ADDR_W-1:0]   ram_wr_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   ram_wr_data,
  input  logic [NUM_PORTS*ADDR_W-1:0]   cons_rd_ptr,
  output logic [NUM_PORTS-1:0]          port_full,
  output logic                          write_enable,
  output logic                          read_enable
);

  if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
    $error("switch_ingress_writer: NUM_PORTS must be in 1..12");
  end
  if (ADDR_W > 16 || DROP_CNT_W > 16 || DATA_W > 32) begin : g_bad_widths
    $error("switch_ingress_writer: ADDR_W/DROP_CNT_W must be <= 16, DATA_W <= 32");
  end

  logic                  wr_acc;
  logic                  rd_acc;
  logic [NUM_PORTS-1:0]  full_vec;
  logic [ADDR_W-1:0]     used_arr [NUM_PORTS];
  logic [DROP_CNT_W-1:0] drop_arr [NUM_PORTS];
  logic                  write_enable_reg;
  logic                  read_enable_reg;
  logic [31:0]           readdata_reg;
  logic [31:0]           readdata_next;

  assign wr_acc = chipselect & write;
  assign rd_acc = chipselect & read;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    ingress_port_ctrl #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DROP_CNT_W (DROP_CNT_W)
    ) u_port (
      .clk         (clk),
      .reset       (reset),
      .push        (wr_acc && (address == port_reg_addr(gi))),
      .push_data   (writedata[DATA_W-1:0]),
      .clear       (wr_acc && (address == REG_CLEAR) && writedata[gi]),
      .cons_rd_ptr (cons_rd_ptr[gi*ADDR_W +: ADDR_W]),
      .wren        (ram_wren[gi]),
      .wr_addr     (ram_wr_addr[gi*ADDR_W +: ADDR_W]),
      .wr_data     (ram_wr_data[gi*DATA_W +: DATA_W]),
      .full        (full_vec[gi]),
      .used        (used_arr[gi]),
      .drop_cnt    (drop_arr[gi])
    );
  end

  // Full flags read low while reset is held, whatever the read pointers are
  assign port_full = full_vec & {NUM_PORTS{reset}};

  // Scheduler control bits written from the bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_enable_reg <= 1'b0;
      read_enable_reg  <= 1'b0;
    end else if (wr_acc) begin
      if (address == REG_WREN) write_enable_reg <= writedata[0];
      if (address == REG_RDEN) read_enable_reg  <= writedata[0];
    end
  end

  // Read word selection from current (pre-edge) state
  always_comb begin
    readdata_next = '0;
    case (address)
      REG_STATUS: begin
        readdata_next[STATUS_RDEN_BIT] = read_enable_reg;
        readdata_next[STATUS_WREN_BIT] = write_enable_reg;
        readdata_next[NUM_PORTS-1:0]   = port_full;
      end
      REG_RDEN: readdata_next[0] = read_enable_reg;
      REG_WREN: readdata_next[0] = write_enable_reg;
      default: begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (address == port_reg_addr(p)) begin
            readdata_next = {16'(drop_arr[p]), 16'(used_arr[p])};
          end
        end
      end
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readdata_reg <= '0;
    end else if (rd_acc) begin
      readdata_reg <= readdata_next;
    end
  end

  assign readdata     = readdata_reg;
  assign write_enable = write_enable_reg;
  assign read_enable  = read_enable_reg;

endmodule
